mem_port_arbiter: RTL

Two-requester arbiter that shares one external memory port between two cache controllers (e.g. instruction and data cache). Grants whole line bursts with round-robin fairness, so the beats of one refill or evict never interleave with the other requester's. Sits between the caches' `*_mem` ports and the memory model. Keeps grant, conflict and timeout statistics.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two burst requesters.
// Whole bursts are granted so beats of one line transfer never interleave.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BEATS    = 4,
  parameter int HOLD_MAX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_0,
  input  logic              wr_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              busy_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              rd_1,
  input  logic              wr_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              busy_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_busy,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        grant,
  output logic [31:0]       grant_cnt_0,
  output logic [31:0]       grant_cnt_1,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       timeout_cnt
);

  localparam int BW = $clog2(BEATS);
  localparam int TW = $clog2(HOLD_MAX + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] idle_tmr;
  logic          last;

  logic req_0, req_1, other_req;
  logic accept, burst_end;

  assign req_0 = rd_0 | wr_0;
  assign req_1 = rd_1 | wr_1;
  assign grant = state;

  // Handshake: a beat transfers in a cycle where the owner drives rd or wr
  // and its busy is low; busy mirrors m_busy only for the current owner.
  always_comb begin
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    busy_0  = 1'b1;
    busy_1  = 1'b1;
    case (state)
      GNT0: begin
        m_rd    = rd_0;
        m_wr    = wr_0 & ~rd_0;
        m_addr  = addr_0;
        m_wdata = wdata_0;
        busy_0  = m_busy;
      end
      GNT1: begin
        m_rd    = rd_1;
        m_wr    = wr_1 & ~rd_1;
        m_addr  = addr_1;
        m_wdata = wdata_1;
        busy_1  = m_busy;
      end
      default: ;
    endcase
  end

  assign rdata_0   = m_rdata;
  assign rdata_1   = m_rdata;
  assign accept    = (m_rd | m_wr) & ~m_busy;
  assign burst_end = accept & (beat_cnt == BEAT_LAST);
  assign other_req = (state == GNT0) ? req_1 : req_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      idle_tmr     <= '0;
      last         <= 1'b1;
      grant_cnt_0  <= '0;
      grant_cnt_1  <= '0;
      conflict_cnt <= '0;
      timeout_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_0 && req_1) begin
            conflict_cnt <= conflict_cnt + 32'd1;
            if (last) begin
              state       <= GNT0;
              grant_cnt_0 <= grant_cnt_0 + 32'd1;
            end else begin
              state       <= GNT1;
              grant_cnt_1 <= grant_cnt_1 + 32'd1;
            end
          end else if (req_0) begin
            state       <= GNT0;
            grant_cnt_0 <= grant_cnt_0 + 32'd1;
          end else if (req_1) begin
            state       <= GNT1;
            grant_cnt_1 <= grant_cnt_1 + 32'd1;
          end
        end
        GNT0, GNT1: begin
          if (accept) begin
            idle_tmr <= '0;
            if (burst_end) begin
              beat_cnt <= '0;
              last     <= (state == GNT1);
              // Direct handoff avoids an idle bubble between bursts.
              if (other_req) begin
                if (state == GNT0) begin
                  state       <= GNT1;
                  grant_cnt_1 <= grant_cnt_1 + 32'd1;
                end else begin
                  state       <= GNT0;
                  grant_cnt_0 <= grant_cnt_0 + 32'd1;
                end
              end else begin
                state <= IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (idle_tmr == HOLD_LAST) begin
            state       <= IDLE;
            idle_tmr    <= '0;
            beat_cnt    <= '0;
            last        <= (state == GNT1);
            timeout_cnt <= timeout_cnt + 32'd1;
          end else begin
            idle_tmr <= idle_tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
